// File: rtl/hack_screen_pkg.sv
// Shared screen geometry, FSM state type and pixel addressing helper for the
// screen-RAM writers (vga_screen_writer, vga_screen_ctrl).
package hack_screen_pkg;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS         = 8192;
    localparam int PIX_PER_WORD  = 16;
    localparam int WORDS_PER_ROW = SCREEN_W / PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        CLR  = 2'd3
    } screen_state_t;

    typedef struct packed {
        logic [12:0] word;
        logic [3:0]  bit_idx;
    } pixel_loc_t;

    // A row is 32 words, so the word address is simply {y, x[8:4]} and the
    // low four bits of x pick the pixel inside that word.
    function automatic pixel_loc_t pixel_loc(input logic [8:0] x, input logic [7:0] y);
        pixel_loc_t loc;
        loc.word    = {y, x[8:4]};
        loc.bit_idx = x[3:0];
        return loc;
    endfunction

endpackage

// File: rtl/vga_screen_writer.sv
// Pixel writer for a 512x256 monochrome screen RAM. Single pixels are written
// with a read-modify-write of the containing 16-bit word; an optional clear
// engine fills the whole RAM with one colour, one word per cycle.
module vga_screen_writer
    import hack_screen_pkg::*;
#(
    parameter bit CLEAR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_x,
    input  logic [8:0]  req_y,
    input  logic        req_color,
    input  logic        clear_req,
    input  logic        clear_color,
    output logic        busy,
    output logic [12:0] ram_addr,
    output logic        ram_wen,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    localparam logic [9:0]  X_LIMIT  = 10'(SCREEN_W);
    localparam logic [8:0]  Y_LIMIT  = 9'(SCREEN_H);
    localparam logic [12:0] CLR_LAST = 13'(WORDS - 1);

    screen_state_t state;
    screen_state_t state_next;

    logic [12:0] cap_word;
    logic [3:0]  cap_bit;
    logic        cap_color;

    logic [12:0] clr_cnt;
    logic        clr_color;
    logic        clear_pending;

    logic        clear_hit;
    logic        accept;
    logic        in_range;
    pixel_loc_t  req_loc;

    assign clear_hit = CLEAR_ENABLE && clear_req;
    assign in_range  = (req_x < X_LIMIT) && (req_y < Y_LIMIT);
    assign req_loc   = pixel_loc(req_x[8:0], req_y[7:0]);
    assign req_ready = (state == IDLE) && !clear_hit && !clear_pending;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE) || clear_pending;

    // Next-state logic: a clear (new or deferred) beats a pixel, out-of-range pixels are swallowed in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_hit || clear_pending) begin
                    state_next = CLR;
                end else if (accept && in_range) begin
                    state_next = RD;
                end
            end
            RD:  state_next = WR;
            WR:  state_next = IDLE;
            CLR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM drive is decoded from the state alone, so reset silences the bus without waiting for a clock.
    always_comb begin
        ram_addr  = '0;
        ram_wen   = 1'b0;
        ram_wdata = '0;
        case (state)
            RD: begin
                ram_addr = cap_word;
            end
            WR: begin
                ram_addr           = cap_word;
                ram_wen            = 1'b1;
                ram_wdata          = ram_rdata;
                ram_wdata[cap_bit] = cap_color;
            end
            CLR: begin
                ram_addr  = clr_cnt;
                ram_wen   = 1'b1;
                ram_wdata = {16{clr_color}};
            end
            default: begin
                ram_addr  = '0;
                ram_wen   = 1'b0;
                ram_wdata = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the target word, bit and colour of every accepted pixel request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_word  <= '0;
            cap_bit   <= '0;
            cap_color <= 1'b0;
        end else if (accept) begin
            cap_word  <= req_loc.word;
            cap_bit   <= req_loc.bit_idx;
            cap_color <= req_color;
        end
    end

    // Clear bookkeeping: defer requests that arrive mid-pixel, restart the counter on entry, ignore requests while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_pending <= 1'b0;
            clr_color     <= 1'b0;
            clr_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == CLR) begin
                        clear_pending <= 1'b0;
                        clr_cnt       <= '0;
                        if (!clear_pending) begin
                            clr_color <= clear_color;
                        end
                    end
                end
                RD, WR: begin
                    if (clear_hit) begin
                        clear_pending <= 1'b1;
                        clr_color     <= clear_color;
                    end
                end
                CLR: begin
                    clr_cnt <= clr_cnt + 13'd1;
                end
                default: begin
                    clear_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
